// File: rtl/bk32_unadd_pipe.sv
// ----------------------------------------------------------------------------
// bk32_unadd_pipe
//
// Pipelined inverse of the Brent-Kung adder datapath. Given a (WIDTH+1)-bit
// sum word and one WIDTH-bit addend b, recovers the other addend as sum - b
// and flags words that no pair of WIDTH-bit addends could have produced.
// Three register stages with a valid/ready stream on both sides.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   input word valid
//   in_ready   block accepts the input word this cycle (combinational)
//   in_sum     [WIDTH:0]   sum word, bit WIDTH is the original carry-out
//   in_b       [WIDTH-1:0] known addend
//   in_tag     [7:0]       opaque sideband, returned with the result
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_a      [WIDTH-1:0] low WIDTH bits of in_sum - in_b
//   out_err    in_sum < in_b, or in_sum - in_b >= 2^WIDTH
//   out_tag    [7:0]       in_tag of the same word
// ----------------------------------------------------------------------------
module bk32_unadd_pipe #(
    parameter int WIDTH      = 32,
    parameter int PIPE_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_sum,
    input  logic [WIDTH-1:0] in_b,
    input  logic [7:0]       in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic             out_err,
    output logic [7:0]       out_tag
);

    // N bits take part in the add; the prefix tree is padded to the next
    // power of two above N. Padding sits above every real bit, so it never
    // feeds a carry we use.
    localparam int N = WIDTH + 1;
    localparam int M = 2 * WIDTH;
    localparam int L = $clog2(M);

    generate
        if (PIPE_DEPTH != 3) begin : g_bad_depth
            $error("bk32_unadd_pipe: PIPE_DEPTH must be 3");
        end
        if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $error("bk32_unadd_pipe: WIDTH must be a power of two in 8..64");
        end
    endgenerate

    // ---------------------------------------------------------------- control
    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    assign adv3      = out_ready | ~v3;
    assign adv2      = adv3 | ~v2;
    assign adv1      = adv2 | ~v1;
    assign in_ready  = adv1;
    assign out_valid = v3;

    // ------------------------------------------------------- stage 1 (g/p)
    // Subtraction is sum + ~b + 1 with ~b zero-extended to N bits.
    // The +1 carry-in is folded into bit 0's generate.
    logic [N-1:0] x_op, y_op;
    logic [N-1:0] g1_d, p1_d;
    logic [N-1:0] g1, p1;
    logic [7:0]   tag1;

    assign x_op = in_sum;
    assign y_op = {1'b0, ~in_b};

    always_comb begin
        g1_d    = x_op & y_op;
        p1_d    = x_op ^ y_op;
        g1_d[0] = x_op[0] | y_op[0];
    end

    // --------------------------------------------------- stage 2 (up-sweep)
    logic [M-1:0] up_g, up_p;
    logic [M-1:0] gu2, pu2;
    logic [N-1:0] pb2;
    logic [7:0]   tag2;

    always_comb begin
        logic [M-1:0] tg;
        logic [M-1:0] tp;
        tg         = '0;
        tp         = '0;
        tg[N-1:0]  = g1;
        tp[N-1:0]  = p1;
        for (int lvl = 0; lvl < L; lvl++) begin
            for (int i = (2 << lvl) - 1; i < M; i += (2 << lvl)) begin
                tg[i] = tg[i] | (tp[i] & tg[i - (1 << lvl)]);
                tp[i] = tp[i] & tp[i - (1 << lvl)];
            end
        end
        up_g = tg;
        up_p = tp;
    end

    // ------------------------------------------ stage 3 (down-sweep + sum)
    logic [M-1:0]     carry_grp;   // carry_grp[i] = carry out of bit i
    logic [WIDTH+1:0] d_full;
    logic [WIDTH-1:0] a_d;
    logic             err_d;

    always_comb begin
        logic [M-1:0] tg;
        tg = gu2;
        for (int lvl = L - 2; lvl >= 0; lvl--) begin
            for (int i = 3 * (1 << lvl) - 1; i < M; i += (2 << lvl)) begin
                tg[i] = tg[i] | (pu2[i] & tg[i - (1 << lvl)]);
            end
        end
        carry_grp = tg;
    end

    always_comb begin
        d_full           = '0;
        d_full[0]        = ~pb2[0];
        for (int i = 1; i < N; i++) begin
            d_full[i] = pb2[i] ^ carry_grp[i - 1];
        end
        d_full[WIDTH+1]  = carry_grp[N - 1];
    end

    // d = sum - b + 2^WIDTH. Only the window [2^WIDTH, 2^(WIDTH+1)) maps to a
    // representable result, i.e. top two bits 01; anything else is a borrow
    // (00) or an overflow (10).
    assign a_d   = d_full[WIDTH-1:0];
    assign err_d = d_full[WIDTH+1] | ~d_full[WIDTH];

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            g1      <= '0;
            p1      <= '0;
            tag1    <= '0;
            gu2     <= '0;
            pu2     <= '0;
            pb2     <= '0;
            tag2    <= '0;
            out_a   <= '0;
            out_err <= 1'b0;
            out_tag <= '0;
        end else begin
            if (adv1) begin
                v1   <= in_valid;
                g1   <= g1_d;
                p1   <= p1_d;
                tag1 <= in_tag;
            end
            if (adv2) begin
                v2   <= v1;
                gu2  <= up_g;
                pu2  <= up_p;
                pb2  <= p1;
                tag2 <= tag1;
            end
            if (adv3) begin
                v3      <= v2;
                out_a   <= a_d;
                out_err <= err_d;
                out_tag <= tag2;
            end
        end
    end

endmodule

// File: tb/tb_bk32_unadd_pipe.sv
module tb_bk32_unadd_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   in_sum;
    logic [W-1:0] in_b;
    logic [7:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_a;
    logic         out_err;
    logic [7:0]   out_tag;

    always #5 clk = ~clk;

    bk32_unadd_pipe #(.WIDTH(W), .PIPE_DEPTH(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sum   (in_sum),
        .in_b     (in_b),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a    (out_a),
        .out_err  (out_err),
        .out_tag  (out_tag)
    );

    typedef struct packed {
        logic [7:0]   tag;
        logic         err;
        logic [W-1:0] a;
    } res_t;

    int   passed = 0;
    int   total  = 0;
    res_t q[$];
    int   emit_cyc[$];
    int   cyc_cnt  = 0;
    int   emit_cnt = 0;
    int   acc_cnt  = 0;
    res_t last_out;
    logic last_in_ready;
    logic hold_pend;
    res_t hold_val;

    // Reference: plain integer subtraction and range test.
    function automatic res_t model(input logic [W:0] s, input logic [W-1:0] b,
                                   input logic [7:0] t);
        longint diff;
        res_t   r;
        diff  = longint'({31'b0, s}) - longint'({32'b0, b});
        r.a   = diff[W-1:0];
        r.err = (diff < 0) || (diff > longint'(64'h0000_0000_FFFF_FFFF));
        r.tag = t;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    // One clock cycle: sample at the falling edge, update the scoreboard,
    // then return just after the next rising edge.
    task automatic cyc();
        res_t o;
        res_t e;
        @(negedge clk);
        cyc_cnt++;
        o = {out_tag, out_err, out_a};
        if (hold_pend) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(o), 64'(hold_val));
        end
        last_in_ready = in_ready;
        if (!rst && in_valid && in_ready) begin
            q.push_back(model(in_sum, in_b, in_tag));
            acc_cnt++;
        end
        if (!rst && out_valid && out_ready) begin
            chk("out_pending", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("result", 64'(o), 64'(e));
            end
            last_out = o;
            emit_cnt++;
            emit_cyc.push_back(cyc_cnt);
        end
        hold_pend = !rst && out_valid && !out_ready;
        hold_val  = o;
        @(posedge clk);
        #1;
    endtask

    task automatic send_lat(input logic [W:0] s, input logic [W-1:0] b, input logic [7:0] t,
                            input logic [W-1:0] ea, input logic ee);
        int n;
        int e0;
        in_sum    = s;
        in_b      = b;
        in_tag    = t;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        e0        = emit_cnt;
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (emit_cnt == e0 && n < 10) begin
            n++;
            cyc();
        end
        chk("latency", 64'(n), 64'd3);
        chk("dir_a", 64'(last_out.a), 64'(ea));
        chk("dir_err", 64'(last_out.err), 64'(ee));
        chk("dir_tag", 64'(last_out.tag), 64'(t));
    endtask

    initial begin
        int   s0;
        int   c0;
        int   a0;
        int   e0;
        int   n;
        int   k;
        int   dlt;
        logic acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_sum    = '0;
        in_b      = '0;
        in_tag    = '0;
        hold_pend = 1'b0;
        last_out  = '0;
        @(posedge clk);
        #1;
        cyc();
        cyc();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_a", 64'(out_a), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        cyc();

        // directed arithmetic vectors and boundaries
        send_lat(33'h1_0000_0000, 32'hFFFF_FFFF, 8'h11, 32'h0000_0001, 1'b0);
        send_lat(33'h0_0000_0005, 32'h0000_0007, 8'h22, 32'hFFFF_FFFE, 1'b1);
        send_lat(33'h1_FFFF_FFFF, 32'hFFFF_FFFF, 8'h33, 32'h0000_0000, 1'b1);
        send_lat(33'h1_FFFF_FFFE, 32'hFFFF_FFFF, 8'h44, 32'hFFFF_FFFF, 1'b0);
        send_lat(33'h0_1234_5678, 32'h1234_5678, 8'h55, 32'h0000_0000, 1'b0);
        send_lat(33'h1_0000_0000, 32'h0000_0000, 8'h66, 32'h0000_0000, 1'b1);
        send_lat(33'h0_FFFF_FFFF, 32'h0000_0000, 8'h77, 32'hFFFF_FFFF, 1'b0);

        // back-to-back stream of 10 words
        emit_cyc.delete();
        out_ready = 1'b1;
        c0 = cyc_cnt + 1;
        for (int i = 0; i < 10; i++) begin
            in_sum   = {1'($urandom_range(0, 1)), $urandom()};
            in_b     = $urandom();
            in_tag   = 8'(i);
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        repeat (6) cyc();
        chk("stream_count", 64'(emit_cyc.size()), 64'd10);
        for (int i = 0; i < 10 && i < emit_cyc.size(); i++)
            chk("stream_cycle", 64'(emit_cyc[i]), 64'(c0 + 3 + i));

        // 5 words with the consumer stalled in cycles 3..6
        emit_cyc.delete();
        a0 = acc_cnt;
        for (int c = 0; c < 15; c++) begin
            k         = acc_cnt - a0;
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (k < 5);
            in_sum    = 33'(k * 123457 + 99);
            in_b      = 32'(k * 9999);
            in_tag    = 8'(8'h80 + k);
            cyc();
            if (c == 3) chk("stall_in_ready", 64'(last_in_ready), 64'd0);
            if (c == 7) chk("release_in_ready", 64'(last_in_ready), 64'd1);
        end
        in_valid = 1'b0;
        chk("stall_count", 64'(emit_cyc.size()), 64'd5);

        // reset with three words in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_sum   = 33'(i + 1000);
            in_b     = 32'(i);
            in_tag   = 8'(8'hA0 + i);
            in_valid = 1'b1;
            cyc();
        end
        rst    = 1'b1;
        in_tag = 8'hEE;
        cyc();
        rst      = 1'b0;
        in_valid = 1'b0;
        q.delete();
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        e0 = emit_cnt;
        repeat (6) cyc();
        chk("no_stale", 64'(emit_cnt - e0), 64'd0);
        send_lat(33'h0_0000_0100, 32'h0000_0001, 8'h5A, 32'h0000_00FF, 1'b0);

        // randomised traffic against the reference model
        in_valid = 1'b0;
        acc      = 1'b0;
        for (int it = 0; it < 20000; it++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_b     = $urandom();
                in_tag   = 8'($urandom());
                if ($urandom_range(0, 3) == 0) begin
                    dlt    = int'($urandom_range(0, 4)) - 2;
                    in_sum = {1'b0, in_b} + 33'(dlt);
                end else begin
                    in_sum = {1'($urandom_range(0, 1)), $urandom()};
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            cyc();
            acc = in_valid && last_in_ready;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            n++;
            cyc();
        end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
